// File: rtl/sdr_read_path_if.sv
// Read-path bundle: command strobes/config from the control path, DQ in, read stream out.
// The master drives commands and DQ; the read path (slave) returns words and BUSY.
interface sdr_read_path_if #(
  parameter int DSIZE = 16,
  parameter int IDW   = 2
);
  logic             RD_CMD;
  logic [IDW-1:0]   RD_ID;
  logic             BST_CMD;
  logic [2:0]       BL;
  logic [1:0]       CL;
  logic [DSIZE-1:0] DQIN;
  logic [DSIZE-1:0] RDATA;
  logic             RDATA_VALID;
  logic             RDATA_LAST;
  logic [IDW-1:0]   RDATA_ID;
  logic             BUSY;

  modport master (
    output RD_CMD, RD_ID, BST_CMD, BL, CL, DQIN,
    input  RDATA, RDATA_VALID, RDATA_LAST, RDATA_ID, BUSY
  );

  modport slave (
    input  RD_CMD, RD_ID, BST_CMD, BL, CL, DQIN,
    output RDATA, RDATA_VALID, RDATA_LAST, RDATA_ID, BUSY
  );
endinterface

// File: rtl/sdr_read_path.sv
// SDRAM read data path: delays READ/BST by CAS latency, captures DQ, emits tagged words.
// First word valid CL+1 clocks after RD_CMD; no back-pressure, host takes every valid word.
module sdr_read_path #(
  parameter int DSIZE = 16,
  parameter int IDW   = 2,
  parameter int PAGE  = 256
) (
  input logic            CLK,
  input logic            RESET_N,
  sdr_read_path_if.slave bus
);
  typedef struct packed {
    logic           rd;
    logic           bst;
    logic [IDW-1:0] id;
    logic [2:0]     bl;
  } cmd_t;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  cmd_t [2:0]       dly;
  cmd_t             tap;
  state_t           state, state_nxt;
  logic [9:0]       cnt, cnt_nxt, len;
  logic             cap_en, cap_end;
  logic             cap_vld, cap_last;
  logic [DSIZE-1:0] cap_dat, out_dat;
  logic [IDW-1:0]   cap_id, cur_id, out_id;
  logic             out_vld, out_last;
  logic             dly_occ;

  assign tap = (bus.CL == 2'd3) ? dly[2] : dly[1];

  always_comb begin
    case (tap.bl)
      3'b001:  len = 10'd2;
      3'b010:  len = 10'd4;
      3'b011:  len = 10'd8;
      3'b111:  len = 10'(PAGE);
      default: len = 10'd1;
    endcase
  end

  // cnt holds the words still to be captured after the current edge
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_en    = 1'b0;
    cap_end   = 1'b0;
    if (tap.rd) begin
      cap_en    = 1'b1;
      cap_end   = (len == 10'd1);
      cnt_nxt   = len - 10'd1;
      state_nxt = cap_end ? IDLE : BURST;
    end else if (state == BURST) begin
      if (tap.bst) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cap_en    = 1'b1;
        cap_end   = (cnt == 10'd1);
        cnt_nxt   = cnt - 10'd1;
        state_nxt = cap_end ? IDLE : BURST;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      dly      <= '0;
      state    <= IDLE;
      cnt      <= '0;
      cur_id   <= '0;
      cap_vld  <= 1'b0;
      cap_last <= 1'b0;
      cap_dat  <= '0;
      cap_id   <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_dat  <= '0;
      out_id   <= '0;
    end else begin
      dly[0]   <= {bus.RD_CMD, bus.BST_CMD & ~bus.RD_CMD, bus.RD_ID, bus.BL};
      dly[2:1] <= dly[1:0];
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      if (tap.rd) cur_id <= tap.id;
      cap_vld  <= cap_en;
      cap_last <= cap_end;
      if (cap_en) begin
        cap_dat <= bus.DQIN;
        cap_id  <= tap.rd ? tap.id : cur_id;
      end
      // a READ or BST at the tap now means the word held in capture closed its burst
      out_vld  <= cap_vld;
      out_last <= cap_vld & (cap_last | tap.rd | tap.bst);
      if (cap_vld) begin
        out_dat <= cap_dat;
        out_id  <= cap_id;
      end
    end
  end

  assign dly_occ = dly[0].rd | dly[0].bst | dly[1].rd | dly[1].bst | dly[2].rd | dly[2].bst;

  assign bus.RDATA       = out_dat;
  assign bus.RDATA_VALID = out_vld;
  assign bus.RDATA_LAST  = out_last;
  assign bus.RDATA_ID    = out_id;
  assign bus.BUSY        = dly_occ | (state == BURST) | cap_vld | out_vld;
endmodule

// File: tb/tb_sdr_read_path.sv
// Bench for sdr_read_path: stimulus tables per edge, expected outputs derived from burst intervals.
module tb_sdr_read_path;
  localparam int DSIZE = 16;
  localparam int IDW   = 2;
  localparam int PAGE  = 256;
  localparam int N     = 3400;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  sdr_read_path_if #(.DSIZE(DSIZE), .IDW(IDW)) bus ();
  sdr_read_path #(.DSIZE(DSIZE), .IDW(IDW), .PAGE(PAGE)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
  );

  logic             rd_a[N], bst_a[N], rst_a[N];
  logic [IDW-1:0]   id_a[N];
  logic [2:0]       bl_a[N];
  logic [1:0]       cl_a[N];
  logic [DSIZE-1:0] dq_a[N];

  logic             cv[N], clst[N];
  int               ce[N];
  logic [DSIZE-1:0] cd[N];
  logic [IDW-1:0]   cid[N];

  logic             ev[N], el[N], eb[N];
  logic [DSIZE-1:0] ed[N];
  logic [IDW-1:0]   ei[N];

  int checks = 0, errors = 0;
  int cyc = 0;
  int top = 0;
  bit run = 0;
  int s1, s2, s3, s4, s5, s6, s7, b;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask

  task automatic new_seg(input int len, input int clv, output int base);
    base = top;
    for (int k = top; k < top + len; k++) begin
      rd_a[k] = 1'b0; bst_a[k] = 1'b0; rst_a[k] = 1'b1;
      id_a[k] = IDW'($urandom); bl_a[k] = 3'($urandom);
      cl_a[k] = 2'(clv); dq_a[k] = DSIZE'($urandom);
    end
    rst_a[top] = 1'b0;
    rst_a[top + 1] = 1'b0;
    top += len;
  endtask

  task automatic rd_at(input int e, input int id, input int bl);
    rd_a[e] = 1'b1; id_a[e] = IDW'(id); bl_a[e] = 3'(bl);
  endtask

  function automatic int blen(input logic [2:0] c);
    case (c)
      3'b001:  return 2;
      3'b010:  return 4;
      3'b011:  return 8;
      3'b111:  return PAGE;
      default: return 1;
    endcase
  endfunction

  function automatic bit rst_between(input int lo, input int hi);
    for (int k = lo + 1; k <= hi && k < N; k++)
      if (!rst_a[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int count_vld(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k < hi; k++) if (ev[k]) c++;
    return c;
  endfunction

  // Each READ owns capture edges [tap, end]; end is cut by the next READ/BST reaching the tap.
  task automatic build_model();
    logic [DSIZE-1:0] hd;
    logic [IDW-1:0]   hi;
    for (int n = 0; n < N; n++) begin
      cv[n] = 1'b0; clst[n] = 1'b0; ce[n] = 0; cd[n] = '0; cid[n] = '0;
    end
    for (int e = 0; e < N; e++) begin
      int t, fin;
      if (!(rd_a[e] && rst_a[e])) continue;
      t = e + int'(cl_a[e]);
      if (t >= N || rst_between(e, t)) continue;
      fin = t + blen(bl_a[e]) - 1;
      for (int e2 = e + 1; e2 <= fin && e2 < N; e2++) begin
        int t2;
        t2 = e2 + int'(cl_a[e2]);
        if ((rd_a[e2] || bst_a[e2]) && rst_a[e2] && t2 > t && t2 <= fin) begin
          fin = t2 - 1;
          break;
        end
      end
      for (int c = t; c <= fin && c < N; c++) begin
        cv[c] = 1'b1; ce[c] = e; cd[c] = dq_a[c]; cid[c] = id_a[e]; clst[c] = (c == fin);
      end
    end
    hd = '0; hi = '0;
    for (int n = 0; n < N; n++) begin
      bit capn, outn, occ;
      capn = cv[n] && !rst_between(ce[n], n);
      outn = (n > 0) && cv[n-1] && !rst_between(ce[n-1], n);
      ev[n] = 1'b0; el[n] = 1'b0;
      if (!rst_a[n]) begin
        hd = '0; hi = '0;
      end else if (outn) begin
        hd = cd[n-1]; hi = cid[n-1]; ev[n] = 1'b1; el[n] = clst[n-1];
      end
      ed[n] = hd; ei[n] = hi;
      occ = 1'b0;
      for (int e = n - 2; e <= n; e++)
        if (e >= 0 && (rd_a[e] || bst_a[e]) && rst_a[e] && !rst_between(e, n)) occ = 1'b1;
      eb[n] = occ | capn | outn;
    end
  endtask

  task automatic drive(input int n);
    RESET_N     = rst_a[n];
    bus.RD_CMD  = rd_a[n];
    bus.RD_ID   = id_a[n];
    bus.BST_CMD = bst_a[n];
    bus.BL      = bl_a[n];
    bus.CL      = cl_a[n];
    bus.DQIN    = dq_a[n];
  endtask

  always @(negedge CLK) begin
    if (run && cyc >= 1 && cyc <= N) begin
      int n;
      n = cyc - 1;
      chk("valid", n, 32'(bus.RDATA_VALID), 32'(ev[n]));
      chk("last",  n, 32'(bus.RDATA_LAST),  32'(el[n]));
      chk("rdata", n, 32'(bus.RDATA),       32'(ed[n]));
      chk("rid",   n, 32'(bus.RDATA_ID),    32'(ei[n]));
      chk("busy",  n, 32'(bus.BUSY),        32'(eb[n]));
    end
  end

  initial begin
    new_seg(30, 2, s1);
    rd_at(s1 + 10, 1, 3'b010);
    for (int k = 0; k < 4; k++) dq_a[s1 + 12 + k] = DSIZE'(16'hA001 + k);
    new_seg(45, 3, s2);
    rd_at(s2 + 20, 3, 3'b011);
    new_seg(40, 2, s3);
    rd_at(s3 + 10, 0, 3'b011);
    rd_at(s3 + 13, 2, 3'b011);
    new_seg(50, 2, s4);
    rd_at(s4 + 10, 1, 3'b111);
    bst_a[s4 + 30] = 1'b1;
    new_seg(25, 2, s5);
    rd_at(s5 + 10, 2, 3'b000);
    bst_a[s5 + 10] = 1'b1;
    new_seg(30, 2, s6);
    rd_at(s6 + 10, 1, 3'b011);
    rst_a[s6 + 14] = 1'b0;
    new_seg(275, 3, s7);
    rd_at(s7 + 5, 3, 3'b111);
    while (top + 45 <= N) begin
      new_seg(45, $urandom_range(2, 3), b);
      for (int k = 2; k <= 25; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          rd_a[b + k] = 1'b1;
          if ($urandom_range(0, 3) == 0) bst_a[b + k] = 1'b1;
        end else if ($urandom_range(0, 7) == 0) begin
          bst_a[b + k] = 1'b1;
        end
      end
      bst_a[b + 27] = 1'b1;
      if ($urandom_range(0, 3) == 0) rst_a[b + $urandom_range(5, 30)] = 1'b0;
    end
    for (int k = top; k < N; k++) begin
      rd_a[k] = 1'b0; bst_a[k] = 1'b0; rst_a[k] = 1'b1; id_a[k] = '0;
      bl_a[k] = '0; cl_a[k] = 2'd2; dq_a[k] = '0;
    end

    build_model();

    chk("model s1 early", s1 + 12, 32'(ev[s1 + 12]), 32'd0);
    chk("model s1 first", s1 + 13, 32'(ev[s1 + 13]), 32'd1);
    chk("model s1 A1",    s1 + 13, 32'(ed[s1 + 13]), 32'hA001);
    chk("model s1 A4",    s1 + 16, 32'(ed[s1 + 16]), 32'hA004);
    chk("model s1 nolast", s1 + 15, 32'(el[s1 + 15]), 32'd0);
    chk("model s1 last",  s1 + 16, 32'(el[s1 + 16]), 32'd1);
    chk("model s1 busy",  s1 + 17, 32'(eb[s1 + 17]), 32'd0);
    chk("model s2 first", s2 + 24, 32'(ev[s2 + 24] & ~ev[s2 + 23]), 32'd1);
    chk("model s2 count", s2, 32'(count_vld(s2, s2 + 45)), 32'd8);
    chk("model s3 count", s3, 32'(count_vld(s3, s3 + 40)), 32'd11);
    chk("model s3 cut",   s3 + 15, 32'(el[s3 + 15]), 32'd1);
    chk("model s3 id",    s3 + 16, 32'(ei[s3 + 16]), 32'd2);
    chk("model s4 count", s4, 32'(count_vld(s4, s4 + 50)), 32'd20);
    chk("model s4 last",  s4 + 32, 32'(el[s4 + 32]), 32'd1);
    chk("model s5 count", s5, 32'(count_vld(s5, s5 + 25)), 32'd1);
    chk("model s6 count", s6, 32'(count_vld(s6, s6 + 30)), 32'd1);
    chk("model s7 count", s7, 32'(count_vld(s7, s7 + 275)), 32'(PAGE));
    chk("model s7 last",  s7 + 264, 32'(el[s7 + 264]), 32'd1);

    drive(0);
    run = 1'b1;
    for (int n = 1; n < N; n++) begin
      @(negedge CLK);
      drive(n);
    end
    @(negedge CLK);
    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
